// File: rtl/mpmp_fifo_pkg.sv
// Shared width rules and count helpers for the multi-push/multi-pop FIFO and its feeders.
package mpmp_fifo_pkg;

    // Widest lane vector the popcount helper accepts.
    localparam int unsigned MaxLanes = 32;

    // Width of a count field that must represent 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Width of an occupancy counter for a 2n-deep staging buffer.
    function automatic int unsigned occ_width(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MaxLanes-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

    function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/mpmp_lane_compact.sv
// Combinational compactor: packs the masked lanes, lowest lane first, into slots 0..k-1.
module mpmp_lane_compact
    import mpmp_fifo_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 13,
    parameter int unsigned NW = cnt_width(N)
) (
    input  logic [N-1:0]          mask_i,
    input  logic [N-1:0][DW-1:0]  data_i,
    output logic [NW-1:0]         count_o,
    output logic [N-1:0][DW-1:0]  packed_o
);

    int unsigned slot;

    assign count_o = NW'(popcount(MaxLanes'(mask_i)));

    // Running slot index is the prefix count of set mask bits below lane p.
    always_comb begin
        packed_o = '0;
        slot     = 0;
        for (int unsigned p = 0; p < N; p++) begin
            if (mask_i[p]) begin
                packed_o[slot] = data_i[p];
                slot++;
            end
        end
    end

endmodule

// File: rtl/multi_push_lane_compactor.sv
// Sparse N-lane input compactor feeding a multi-push FIFO through a 2N-word shift buffer.
module multi_push_lane_compactor
    import mpmp_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned N          = 3,
    parameter int unsigned NW         = cnt_width(N),
    parameter int unsigned DW         = DATA_WIDTH,
    parameter int unsigned BW         = occ_width(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    input  logic [N-1:0]         in_mask_i,
    input  logic [N-1:0][DW-1:0] in_data_i,
    output logic                 in_ready_o,
    output logic [NW-1:0]        push_o,
    output logic [N-1:0][DW-1:0] push_data_o,
    input  logic [NW-1:0]        can_push_i
);

    logic [BW-1:0]           occ_q, occ_d;
    logic [2*N-1:0][DW-1:0]  stage_q, stage_d;

    logic                    accept;
    logic [N-1:0]            acc_mask;
    logic [NW-1:0]           k;
    logic [N-1:0][DW-1:0]    packed_words;
    logic [BW-1:0]           push_w;
    logic [BW-1:0]           base;

    // Ready depends only on occupancy so an accepted beat of up to N words always fits.
    assign in_ready_o = (occ_q <= BW'(N));
    assign accept     = in_valid_i && in_ready_o;
    assign acc_mask   = in_mask_i & {N{accept}};

    mpmp_lane_compact #(
        .N  (N),
        .DW (DW),
        .NW (NW)
    ) u_compact (
        .mask_i   (acc_mask),
        .data_i   (in_data_i),
        .count_o  (k),
        .packed_o (packed_words)
    );

    assign push_w = BW'(min3(32'(occ_q), 32'(can_push_i), N));
    assign push_o = NW'(push_w);
    assign base   = occ_q - push_w;
    assign occ_d  = base + BW'(k);

    always_comb begin
        push_data_o = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (BW'(p) < push_w) push_data_o[p] = stage_q[p];
        end
    end

    // Shift out the pushed words, then append the new beat right behind the survivors.
    always_comb begin
        stage_d = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (i + 32'(push_w) < 2 * N) stage_d[i] = stage_q[i + 32'(push_w)];
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (NW'(j) < k) stage_d[base + BW'(j)] = packed_words[j];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Buffer contents beyond occ_q are don't-care, so the data array needs no reset.
    always_ff @(posedge clk_i) begin
        stage_q <= stage_d;
    end

endmodule

// File: tb/tb_multi_push_lane_compactor.sv
// Directed-vector and scoreboard bench for multi_push_lane_compactor (N=3, DW=13).
module tb_multi_push_lane_compactor;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 13;
    localparam int unsigned NW = 2;

    typedef logic [N-1:0][DW-1:0] lanes_t;

    typedef struct {
        logic          valid;
        logic [N-1:0]  mask;
        lanes_t        data;
        logic [NW-1:0] cp;
        logic          exp_ready;
        logic [NW-1:0] exp_push;
        lanes_t        exp_pd;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  in_mask;
    lanes_t        in_data;
    logic          in_ready;
    logic [NW-1:0] push;
    lanes_t        push_data;
    logic [NW-1:0] can_push;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];

    multi_push_lane_compactor #(
        .DATA_WIDTH (DW),
        .N          (N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_mask_i   (in_mask),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .push_o      (push),
        .push_data_o (push_data),
        .can_push_i  (can_push)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [DW-1:0] WA = 13'h00A1, WB = 13'h00B2, WC = 13'h00C3;
    localparam logic [DW-1:0] WD = 13'h00D4, WE = 13'h00E5, WG = 13'h0107, WH = 13'h0118;
    localparam logic [DW-1:0] W0 = 13'h1000, W1 = 13'h1001, W2 = 13'h1002;
    localparam logic [DW-1:0] W3 = 13'h1003, W4 = 13'h1004, W5 = 13'h1005;
    localparam logic [DW-1:0] WX = 13'h1555, WJ = 13'h1FFF, WZ = 13'h0000;

    function automatic lanes_t mk3(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                   input logic [DW-1:0] l2);
        lanes_t r;
        r[0] = l0;
        r[1] = l1;
        r[2] = l2;
        return r;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [N-1:0] m, input lanes_t d,
                                 input logic [NW-1:0] cp, input logic er,
                                 input logic [NW-1:0] ep, input lanes_t epd);
        vec_t r;
        r.valid = v; r.mask = m; r.data = d; r.cp = cp;
        r.exp_ready = er; r.exp_push = ep; r.exp_pd = epd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic er, input logic [NW-1:0] ep,
                            input lanes_t epd);
        chk({tag, ".ready"}, 64'(in_ready), 64'(er));
        chk({tag, ".push"}, 64'(push), 64'(ep));
        chk({tag, ".push_data"}, 64'(push_data), 64'(epd));
    endtask

    // One scoreboard cycle: drive at negedge, check #1 later, then update the model.
    task automatic step(input logic v, input logic [N-1:0] m, input lanes_t d,
                        input logic [NW-1:0] cp);
        int unsigned ep;
        logic        acc;
        @(negedge clk);
        in_valid = v; in_mask = m; in_data = d; can_push = cp;
        #1;
        ep  = q.size();
        if (ep > cp) ep = cp;
        if (ep > N) ep = N;
        acc = v && (q.size() <= N);
        chk("sb.ready", 64'(in_ready), 64'(q.size() <= N));
        chk("sb.push", 64'(push), 64'(ep));
        chk("sb.push_le_cp", 64'(push <= cp), 64'd1);
        for (int unsigned p = 0; p < N; p++) begin
            if (p < ep) chk("sb.word", 64'(push_data[p]), 64'(q[p]));
            else        chk("sb.idle_lane", 64'(push_data[p]), 64'd0);
        end
        for (int unsigned p = 0; p < ep; p++) void'(q.pop_front());
        if (acc) begin
            for (int unsigned p = 0; p < N; p++) begin
                if (m[p]) q.push_back(d[p]);
            end
        end
    endtask

    vec_t vecs[15];
    lanes_t zz;

    initial begin
        zz = mk3(WZ, WZ, WZ);
        vecs[0]  = mkv(1'b1, 3'b101, mk3(WA, WB, WC), 2'd3, 1'b1, 2'd0, zz);
        vecs[1]  = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3, 1'b1, 2'd2, mk3(WA, WC, WZ));
        vecs[2]  = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3, 1'b1, 2'd0, zz);
        vecs[3]  = mkv(1'b1, 3'b111, mk3(W0, W1, W2), 2'd0, 1'b1, 2'd0, zz);
        vecs[4]  = mkv(1'b1, 3'b111, mk3(W3, W4, W5), 2'd0, 1'b1, 2'd0, zz);
        vecs[5]  = mkv(1'b1, 3'b111, mk3(WX, WX, WX), 2'd0, 1'b0, 2'd0, zz);
        vecs[6]  = mkv(1'b1, 3'b111, mk3(WX, WX, WX), 2'd2, 1'b0, 2'd2, mk3(W0, W1, WZ));
        vecs[7]  = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd1, 1'b0, 2'd1, mk3(W2, WZ, WZ));
        vecs[8]  = mkv(1'b1, 3'b011, mk3(WD, WE, WJ), 2'd1, 1'b1, 2'd1, mk3(W3, WZ, WZ));
        vecs[9]  = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3, 1'b0, 2'd3, mk3(W4, W5, WD));
        vecs[10] = mkv(1'b1, 3'b000, mk3(WJ, WJ, WJ), 2'd0, 1'b1, 2'd0, zz);
        vecs[11] = mkv(1'b1, 3'b100, mk3(WJ, WJ, WG), 2'd3, 1'b1, 2'd1, mk3(WE, WZ, WZ));
        vecs[12] = mkv(1'b1, 3'b010, mk3(WJ, WH, WJ), 2'd2, 1'b1, 2'd1, mk3(WG, WZ, WZ));
        vecs[13] = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3, 1'b1, 2'd1, mk3(WH, WZ, WZ));
        vecs[14] = mkv(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3, 1'b1, 2'd0, zz);

        rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; can_push = 2'd3;
        #2;
        chk_outs("reset_hold", 1'b1, 2'd0, zz);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid; in_mask = vecs[i].mask;
            in_data = vecs[i].data; can_push = vecs[i].cp;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_push,
                     vecs[i].exp_pd);
        end

        // Fill to 2N with the FIFO blocked, then reset asynchronously mid-cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mask = 3'b111; in_data = mk3(WX, WX, WX); can_push = 2'd0;
        end
        @(negedge clk);
        in_valid = 1'b0; can_push = 2'd0;
        #1;
        chk_outs("full_blocked", 1'b0, 2'd0, zz);
        @(posedge clk);
        #3;
        can_push = 2'd3;
        rst = 1'b1;
        #1;
        chk_outs("async_reset", 1'b1, 2'd0, zz);
        @(negedge clk);
        rst = 1'b0;
        q.delete();

        step(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3);
        step(1'b1, 3'b001, mk3(WB, WJ, WJ), 2'd3);
        step(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3);
        step(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3);

        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 mk3(13'($urandom), 13'($urandom), 13'($urandom)),
                 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 3'b000, mk3(WJ, WJ, WJ), 2'd3);
        chk("drained", 64'(q.size()), 64'd0);
        chk("drained.push", 64'(push), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_push_lane_compactor.md
Name: multi_push_lane_compactor

Overview:
- Upstream feeder for the multi-push/multi-pop FIFO.
- Accepts N input lanes per beat with a sparse per-lane valid mask. Compacts the valid words, lowest lane first, into a 2N-word staging buffer.
- Drives the FIFO's push count and push data, never requesting more than the FIFO's advertised can_push.
- Valid/ready on the input side; FIFO push interface on the output side.

Parameters:
- DATA_WIDTH, 13, width of one data word.
- N, 3, number of input lanes and maximum push count per cycle; must match the downstream FIFO.
- NW, $clog2(N+1), width of count fields (push_o, can_push_i).
- DW, DATA_WIDTH, short alias.
- BW, $clog2(2*N+1), width of the staging-buffer occupancy counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- in_valid_i  input  1  input beat valid.
- in_mask_i  input  N  per-lane valid; bit p qualifies in_data_i[p].
- in_data_i  input  [N-1:0][DW-1:0]  input lane words.
- in_ready_o  output  1  beat accepted when in_valid_i && in_ready_o.
- push_o  output  NW  number of words pushed to the FIFO this cycle.
- push_data_o  output  [N-1:0][DW-1:0]  words to push; lane 0 is the oldest.
- can_push_i  input  NW  FIFO free-slot count (registered in the FIFO).

Behaviour:
- Reset: rst_i asynchronously clears the occupancy counter occ_l to 0 and leaves buffer data don't-care. While in reset and after it: push_o=0, push_data_o=0, in_ready_o=1.
- Staging buffer: buf[0..2N-1] with occ_l in [0, 2N]. buf[0] is the oldest word.
- in_ready_o = (occ_l <= N). It depends only on registered state, never on in_valid_i, in_mask_i or can_push_i.
- Push count is combinational: push_o = min(occ_l, can_push_i, N). The block never issues push_o > can_push_i, so the FIFO never drops a request.
- push_data_o[p] = buf[p] for p < push_o; lanes p >= push_o are driven 0.
- Compaction: k = popcount(in_mask_i & {N{accept}}), where accept = in_valid_i && in_ready_o. Valid lanes are packed in ascending lane order: the j-th set mask bit maps to compacted slot j.
- Next state, same cycle:
  - Shift the buffer down by push_o.
  - Write compacted word j to buf[occ_l - push_o + j] for j < k.
  - occ_next = occ_l - push_o + k.
  - Overflow is impossible by construction: accept requires occ_l <= N and k <= N.
- Latency: a word accepted in cycle t can appear on push_data_o at t+1 at the earliest.
- Ordering: strict FIFO order across beats and within a beat (ascending lane).
- Boundary conditions:
  - in_valid_i=1 with in_mask_i=0: the beat is accepted and consumed; occ_l is unchanged except by push_o.
  - can_push_i=0: push_o=0; the buffer fills and in_ready_o drops once occ_l > N.
  - Simultaneous accept and push in one cycle is fully supported; the shift and the append use the same push_o.
  - occ_l = 2N: in_ready_o=0 and push_o = min(N, can_push_i).
  - in_data_i lanes with mask bit 0 never reach the buffer, whatever their values.
  - Reset asserted mid-stream discards all buffered words; no partial push is issued after deassertion.
- Arithmetic: every occupancy and index sum is computed at BW width. No wrap-around is needed because the buffer is shift-based, not circular.

Decomposition:
- Shared package mpmp_fifo_pkg: the NW/BW width derivation functions, a popcount function, and the min-of-counts function. The same width rules are reused by the FIFO.
- One sub-module, mpmp_lane_compact: purely combinational prefix-sum compactor. It takes (mask, data[N]) and produces (count k, packed[N]).
- The top level holds occ_l, the buffer registers, the shift/append logic and the handshake.

Test Plan (N=3, DW=13):
1. Reset with rst_i pulsed mid-cycle, asynchronously -> push_o=0, push_data_o=0 and in_ready_o=1 immediately; occ_l=0 after release.
2. Beat mask=3'b101, data {C,B,A}, can_push_i=3 -> next cycle push_o=2, push_data_o[0]=A, [1]=C, [2]=0; then occ returns to 0.
3. can_push_i=0, three beats of mask=3'b111 -> beats 1 and 2 accepted (occ 3, then 6); in_ready_o=0 at occ=6; push_o stays 0; third beat stalls.
4. From occ=6, can_push_i=2 for one cycle -> push_o=2 with the oldest two words; occ 6->4; in_ready_o stays 0; order preserved.
5. occ=3, can_push_i=1, simultaneous beat mask=3'b011 {E,D} -> push_o=1, occ_next=4, new words land at buf[2..3] after the two older words.
6. Random masks and can_push_i over 10k cycles against a scoreboard -> output word sequence equals input valid-word sequence; push_o <= can_push_i every cycle; no loss or duplication.
